// File: rtl/uart_pkg.sv
// Shared UART definitions: rx FSM encodings, frame width and the baud divider helper.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef logic [2:0] rx_state_t;

    localparam rx_state_t RX_IDLE  = 3'd0;
    localparam rx_state_t RX_START = 3'd1;
    localparam rx_state_t RX_DATA  = 3'd2;
    localparam rx_state_t RX_STOP  = 3'd3;
    localparam rx_state_t RX_BREAK = 3'd4;

    // Clocks per oversample tick, truncated.
    function automatic int calc_div(input int clk_freq, input int baudrate, input int oversample);
        return clk_freq / (baudrate * oversample);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle o_tick every DIV clocks, phase realigned by i_restart.
// First tick after a restart arrives DIV cycles later; no backpressure.
module uart_baud_tick #(
    parameter int DIV = 325
) (
    input  logic clk,
    input  logic rst,
    input  logic i_restart,
    output logic o_tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_restart) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // A restart suppresses any tick that would coincide with it.
    assign o_tick = (r_cnt == LAST) && !i_restart;

endmodule

// File: rtl/uart_rx.sv
// 8N1 oversampling UART receiver with 3-sample majority vote; byte held on valid until read.
// Valid rises 1 cycle after the mid-stop sample (+2 sync cycles); unread bytes are overwritten with an overrun pulse.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUDRATE   = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic                 read,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int DIV = calc_div(CLK_FREQ, BAUDRATE, OVERSAMPLE);
    localparam int TW  = $clog2(OVERSAMPLE);
    localparam int BW  = $clog2(DATA_BITS);

    localparam logic [TW-1:0] T_LO   = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] T_HI   = TW'(OVERSAMPLE / 2 + 1);
    localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

    logic                 r_rx_meta;
    logic                 r_rx_s;
    logic                 r_rx_prev;
    rx_state_t            r_state;
    logic [TW-1:0]        r_tick;
    logic [BW-1:0]        r_bit;
    logic [1:0]           r_samp;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_frame_err;
    logic                 r_overrun;

    logic w_tick;
    logic w_fall;
    logic w_restart;
    logic w_maj;
    logic w_decide;
    logic w_bit_end;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
            r_rx_prev <= r_rx_s;
        end
    end

    assign w_fall    = r_rx_prev && !r_rx_s;
    assign w_restart = (r_state == RX_IDLE) && w_fall;

    uart_baud_tick #(
        .DIV (DIV)
    ) u_baud_tick (
        .clk       (clk),
        .rst       (rst),
        .i_restart (w_restart),
        .o_tick    (w_tick)
    );

    // The third vote is the live synchronized sample at the decision tick.
    assign w_maj     = (r_samp[0] & r_samp[1]) | (r_samp[0] & r_rx_s) | (r_samp[1] & r_rx_s);
    assign w_decide  = w_tick && (r_tick == T_HI);
    assign w_bit_end = w_tick && (r_tick == T_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= RX_IDLE;
            r_tick      <= '0;
            r_bit       <= '0;
            r_samp      <= '0;
            r_shift     <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;

            if (read && r_valid) begin
                r_valid <= 1'b0;
            end

            if (w_tick) begin
                r_tick <= (r_tick == T_LAST) ? '0 : r_tick + TW'(1);
                if (r_tick == T_LO) begin
                    r_samp[0] <= r_rx_s;
                end
                if (r_tick == T_MID) begin
                    r_samp[1] <= r_rx_s;
                end
            end

            case (r_state)
                RX_IDLE: begin
                    if (w_fall) begin
                        r_state <= RX_START;
                        r_tick  <= '0;
                        r_bit   <= '0;
                    end
                end
                RX_START: begin
                    if (w_decide && w_maj) begin
                        r_state <= RX_IDLE;
                    end else if (w_bit_end) begin
                        r_state <= RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (w_decide) begin
                        r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
                    end
                    if (w_bit_end) begin
                        r_bit <= r_bit + BW'(1);
                        if (r_bit == B_LAST) begin
                            r_state <= RX_STOP;
                        end
                    end
                end
                RX_STOP: begin
                    // Deciding at mid-stop frees IDLE in time for a back-to-back start bit.
                    if (w_decide) begin
                        if (w_maj) begin
                            r_data    <= r_shift;
                            r_valid   <= 1'b1;
                            r_overrun <= r_valid && !read;
                            r_state   <= RX_IDLE;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= RX_BREAK;
                        end
                    end
                end
                RX_BREAK: begin
                    if (r_rx_s) begin
                        r_state <= RX_IDLE;
                    end
                end
                default: begin
                    r_state <= RX_IDLE;
                end
            endcase
        end
    end

    assign data      = r_data;
    assign valid     = r_valid;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
    assign busy      = (r_state != RX_IDLE);

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Oversampling UART receiver; the receiving end of the serial link driven by uart_tx (8N1, LSB first, idle high).
- Recovers bytes from the asynchronous rx pin and presents them on a valid/read handshake.
- Feeds the csoc_test command decoder.
- Also instantiated in benches to capture bytes sent back on tx.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUDRATE, 9600, line bit rate in bits/s.
- OVERSAMPLE, 16, sample ticks per bit period; must be even and at least 8.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- rx  input  1  asynchronous serial line, idle high.
- read  input  1  consumer acknowledge; clears valid.
- data  output  8  last good received byte.
- valid  output  1  level; a byte is waiting in data.
- frame_err  output  1  one-cycle pulse; stop bit sampled low.
- overrun  output  1  one-cycle pulse; a new byte landed while valid was still 1.
- busy  output  1  high from start-bit detect until the frame ends.

Behaviour:
- Single clock domain: clk. Reset is synchronous and active-high: rst sampled on the clk rising edge.
- Reset values: data=0, valid=0, frame_err=0, overrun=0, busy=0, state=IDLE, sync flops=1, all counters=0.
- Reset mid-frame aborts reception; no outputs are asserted afterwards.
- Input synchronizer: rx passes through 2 flops (rx_s); this adds 2 cycles of latency.
- Tick generator:
  - DIV = CLK_FREQ/(BAUDRATE*OVERSAMPLE), integer truncation; 325 at the defaults.
  - Produces a 1-cycle tick every DIV clocks.
  - The phase restarts at start-bit detection.
- Majority sampling: each bit value is the majority of rx_s at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 within that bit (7, 8, 9 at the defaults).
- The tick counter wraps from OVERSAMPLE-1 to 0 and advances the bit.
- FSM states:
  - IDLE: on a falling edge of rx_s, go to START and set busy=1.
  - START: at the mid-bit decision, majority 1 means a false start: go to IDLE, busy=0, no flags. Majority 0 goes to DATA at the bit end.
  - DATA: 8 bits, LSB first, shifted into the shift register. After bit 7 ends, go to STOP.
  - STOP: the decision is made at mid-stop (tick OVERSAMPLE/2+1), not at the bit end.
    - Majority 1: data<=shift and valid<=1 on the next cycle. If valid was already 1 and read is not asserted that cycle, pulse overrun and overwrite data. Then go to IDLE with busy=0.
    - Majority 0: pulse frame_err, leave data and valid unchanged, go to BREAK.
  - BREAK: wait until rx_s=1, then go to IDLE and drop busy=0. A held-low line therefore produces exactly one frame_err.
- Handshake:
  - read while valid=1 clears valid on the next cycle.
  - read while valid=0 is ignored.
  - A new byte completing in the same cycle as read leaves valid=1, loads the new data, and raises no overrun.
- Returning to IDLE at mid-stop allows a back-to-back start bit to be detected with no lost frame.
- Latency: about 1 cycle from the mid-stop sample to valid rising, plus 2 cycles of synchronizer delay.

Decomposition:
- Shared package uart_pkg:
  - rx state enum {IDLE, START, DATA, STOP, BREAK}.
  - Function calc_div(CLK_FREQ, BAUDRATE, OVERSAMPLE), also reused by uart_tx.
  - Constant DATA_BITS=8.
- One sub-module: uart_baud_tick (counter with a restart input, producing the tick pulse). It is shared with uart_tx.

Test Plan:
- Drive uart_tx (9600 baud, 50 MHz) with 0x55 -> valid rises once; data=0x55; frame_err=0, overrun=0; busy falls at mid-stop.
- Send 0xA5 then 0x3C back-to-back, with read pulsed after each valid -> data sequence 0xA5 then 0x3C; no lost byte, no overrun.
- Drive a 2000-cycle low glitch on rx (shorter than half a bit, 2600 cycles) -> FSM returns to IDLE; valid, frame_err and busy all end at 0.
- Drive a hand-built frame carrying 0x81 with the stop bit low -> one frame_err pulse at mid-stop; valid stays 0; busy stays 1 until rx returns high.
- Receive 0x11 with no read, then 0x22 -> overrun pulses once; data=0x22; valid=1. A later read clears valid.
- Assert rst for 1 cycle at mid-DATA of a 0xFF frame -> all outputs 0. The following 0x0F frame is received correctly.
